// File: rtl/panel_pkg.sv
// Shared codes for the front-panel page arbiter: buttons, page owners, arbiter states.
// Pure declarations; no logic, no latency.
package panel_pkg;

  localparam logic [3:0] BTN_UP    = 4'b0001;
  localparam logic [3:0] BTN_LEFT  = 4'b0010;
  localparam logic [3:0] BTN_RIGHT = 4'b0100;
  localparam logic [3:0] BTN_DOWN  = 4'b1000;

  typedef enum logic [1:0] {
    OWN_TIME = 2'd0,
    OWN_CNT  = 2'd1,
    OWN_ALM  = 2'd2
  } owner_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_ALERT  = 1'b1
  } state_t;

  function automatic owner_t next_owner(input owner_t o);
    case (o)
      OWN_TIME: return OWN_CNT;
      OWN_CNT:  return OWN_ALM;
      default:  return OWN_TIME;
    endcase
  endfunction

  // Exactly one bit set: the only edge vectors that count as a button press.
  function automatic logic is_single(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/page_arbiter_if.sv
// Panel bundle between the page arbiter (slave) and its surroundings (master).
// Plain wires; no latency, no flow control.
interface page_arbiter_if;
  logic [3:0]  btn;
  logic        mode_btn;
  logic [31:0] time_data;
  logic [31:0] cnt_data;
  logic [31:0] alm_data;
  logic        alert_req;
  logic [1:0]  owner;
  logic [3:0]  edge_time;
  logic [3:0]  edge_cnt;
  logic [3:0]  edge_alm;
  logic [31:0] disp_data;
  logic        disp_en;
  logic        alert_active;
  logic        alert_ack;

  modport master (
    output btn, mode_btn, time_data, cnt_data, alm_data, alert_req,
    input  owner, edge_time, edge_cnt, edge_alm, disp_data, disp_en, alert_active, alert_ack
  );

  modport slave (
    input  btn, mode_btn, time_data, cnt_data, alm_data, alert_req,
    output owner, edge_time, edge_cnt, edge_alm, disp_data, disp_en, alert_active, alert_ack
  );
endinterface

// File: rtl/key_sampler.sv
// Samples raw keys once per debounce period and flags newly pressed keys.
// edge_vec is high for the one cycle after a sample that saw a key go from released to pressed.
module key_sampler #(
  parameter int W               = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] edge_vec
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic [W-1:0]  key_vc;
  logic [W-1:0]  key_vp;
  logic          wrap;

  assign wrap = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      key_vc <= '0;
      key_vp <= '0;
    end else begin
      cnt    <= wrap ? '0 : cnt + 1'b1;
      key_vp <= key_vc;
      if (wrap) key_vc <= raw;
    end
  end

  assign edge_vec = ~key_vp & key_vc;

endmodule

// File: rtl/page_arbiter.sv
// Shares display and buttons between time/countdown/alarm pages; alerts preempt to the alarm page.
// Outputs registered: button pulse 1 cycle after sampling, alert entry 2 cycles after alert_req rises.
module page_arbiter
  import panel_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ALERT_HOLD_S    = 10
) (
  input logic           clk,
  input logic           rst,
  page_arbiter_if.slave bus
);

  localparam int HALF   = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int SEC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int HOLD_W = $clog2(ALERT_HOLD_S + 1);

  logic [4:0]        ev;
  logic              valid_edge, mode_edge, btn_edge;
  logic              req_q1, req_q2, alert_rise, hold_done;
  state_t            state;
  owner_t            owner_q, saved_owner;
  logic [SEC_W-1:0]  sec_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HALF_W-1:0] blink_cnt;
  logic [3:0]        edge_time_q, edge_cnt_q, edge_alm_q;
  logic [31:0]       disp_q;
  logic              disp_en_q, ack_q;

  key_sampler #(
    .W               (5),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_keys (
    .clk      (clk),
    .rst      (rst),
    .raw      ({bus.mode_btn, bus.btn}),
    .edge_vec (ev)
  );

  assign valid_edge = is_single(ev);
  assign mode_edge  = valid_edge & ev[4];
  assign btn_edge   = valid_edge & ~ev[4];
  assign alert_rise = req_q1 & ~req_q2;
  // Last cycle of the last hold second: leaving here gives exactly ALERT_HOLD_S*CLK_HZ cycles in ALERT.
  assign hold_done  = (sec_cnt == SEC_W'(CLK_HZ - 1)) && (hold_cnt == HOLD_W'(ALERT_HOLD_S - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_NORMAL;
      owner_q     <= OWN_TIME;
      saved_owner <= OWN_TIME;
      req_q1      <= 1'b0;
      req_q2      <= 1'b0;
      sec_cnt     <= '0;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      edge_time_q <= '0;
      edge_cnt_q  <= '0;
      edge_alm_q  <= '0;
      disp_q      <= '0;
      disp_en_q   <= 1'b1;
      ack_q       <= 1'b0;
    end else begin
      req_q1      <= bus.alert_req;
      req_q2      <= req_q1;
      edge_time_q <= '0;
      edge_cnt_q  <= '0;
      edge_alm_q  <= '0;
      ack_q       <= 1'b0;

      case (owner_q)
        OWN_CNT: disp_q <= bus.cnt_data;
        OWN_ALM: disp_q <= bus.alm_data;
        default: disp_q <= bus.time_data;
      endcase

      case (state)
        ST_NORMAL: begin
          if (alert_rise) begin
            state       <= ST_ALERT;
            saved_owner <= owner_q;
            owner_q     <= OWN_ALM;
            sec_cnt     <= '0;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            disp_en_q   <= 1'b1;
          end else if (mode_edge) begin
            owner_q <= next_owner(owner_q);
          end else if (btn_edge) begin
            case (owner_q)
              OWN_CNT: edge_cnt_q  <= ev[3:0];
              OWN_ALM: edge_alm_q  <= ev[3:0];
              default: edge_time_q <= ev[3:0];
            endcase
          end
        end
        ST_ALERT: begin
          if (blink_cnt == HALF_W'(HALF - 1)) begin
            blink_cnt <= '0;
            disp_en_q <= ~disp_en_q;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
          // A re-trigger outranks a coincident press or timeout; the press is swallowed.
          if (alert_rise) begin
            sec_cnt  <= '0;
            hold_cnt <= '0;
          end else if (valid_edge || hold_done) begin
            state     <= ST_NORMAL;
            owner_q   <= saved_owner;
            disp_en_q <= 1'b1;
            ack_q     <= valid_edge;
          end else if (sec_cnt == SEC_W'(CLK_HZ - 1)) begin
            sec_cnt  <= '0;
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            sec_cnt <= sec_cnt + 1'b1;
          end
        end
        default: state <= ST_NORMAL;
      endcase
    end
  end

  assign bus.owner        = owner_q;
  assign bus.edge_time    = edge_time_q;
  assign bus.edge_cnt     = edge_cnt_q;
  assign bus.edge_alm     = edge_alm_q;
  assign bus.disp_data    = disp_q;
  assign bus.disp_en      = disp_en_q;
  assign bus.alert_active = (state == ST_ALERT);
  assign bus.alert_ack    = ack_q;

endmodule
